// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: mode codes and control state encoding shared by the alu_seq slice
package alu_seq_pkg;
  localparam logic [2:0] MODE_INC   = 3'd0;
  localparam logic [2:0] MODE_ADD   = 3'd1;
  localparam logic [2:0] MODE_ACC   = 3'd2;
  localparam logic [2:0] MODE_LOGIC = 3'd3;
  localparam logic [2:0] MODE_RED   = 3'd4;
  localparam logic [2:0] MODE_SHL   = 3'd5;
  localparam logic [2:0] MODE_SHR   = 3'd6;
  localparam logic [2:0] MODE_MUL   = 3'd7;
  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier datapath, one multiplier bit per cycle
module alu_seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  logic [W2-1:0]    mcand;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  // product is the accumulator after the current step, so the top can capture it on the final edge
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= W2'(a);
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU on operand a and result register (B = low half), iterative multiply
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [2:0]         mode,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero
);
  localparam int W2 = 2 * WIDTH;
  state_t state, state_next;
  logic [WIDTH-1:0] b;
  logic [W2-1:0]    op_val;
  logic [W2-1:0]    product;
  logic             last;
  logic             accept;
  logic             big_shift;
  assign b         = result[WIDTH-1:0];
  assign busy      = state == MUL;
  assign zero      = result == '0;
  assign accept    = start && state == IDLE;
  assign big_shift = W2'(a) >= W2'(W2);
  always_comb begin
    op_val = '0;
    case (mode)
      MODE_INC:   op_val = W2'(a) + 1'b1;
      MODE_ADD:   op_val = W2'(a) + W2'(b);
      MODE_ACC:   op_val = result + W2'(a);
      MODE_LOGIC: op_val = {a | b, a ^ b};
      MODE_RED:   op_val = W2'(|{a, b});
      MODE_SHL:   op_val = big_shift ? '0 : W2'(b) << a;
      MODE_SHR:   op_val = big_shift ? '0 : W2'(b) >> a;
      default:    op_val = '0;
    endcase
  end
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? ((accept && mode == MODE_MUL) ? MUL : IDLE)
                                 : (last ? IDLE : MUL);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      done   <= (accept && mode != MODE_MUL) || (state == MUL && last);
      if (accept && mode != MODE_MUL)
        result <= op_val;
      else if (state == MUL && last)
        result <= product;
    end
  end
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (accept && mode == MODE_MUL),
    .run     (state == MUL),
    .a       (a),
    .b       (b),
    .product (product),
    .last    (last)
  );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 4;
  localparam int M = 1 << (2 * W);
  logic         clock = 0;
  logic         reset = 1;
  logic [W-1:0] a = '0;
  logic [2:0]   mode = '0;
  logic         start = 0;
  logic         busy, done, zero;
  logic [2*W-1:0] result;
  int checks = 0;
  int failures = 0;
  int exp_res = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .a(a), .mode(mode), .start(start),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clock = ~clock;

  function automatic int model(input int m, input int av, input int r);
    int bv;
    bv = r % (1 << W);
    case (m)
      0: return av + 1;
      1: return av + bv;
      2: return (r + av) % M;
      3: return ((av | bv) << W) | (av ^ bv);
      4: return (av != 0 || bv != 0) ? 1 : 0;
      5: return (av >= 2 * W) ? 0 : (bv * (1 << av)) % M;
      6: return (av >= 2 * W) ? 0 : bv / (1 << av);
      default: return av * bv;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic single_op(input int m, input int av);
    int e;
    e = model(m, av, exp_res);
    mode = 3'(m); a = W'(av); start = 1;
    cycle();
    start = 0;
    checks++; if (result !== (2*W)'(e)) begin failures++; $display("FAIL single_res mode=%0d a=%0d got=%h exp=%h", m, av, result, e); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_flags mode=%0d got done=%b busy=%b exp done=1 busy=0", m, done, busy); end
    checks++; if (zero !== (e == 0)) begin failures++; $display("FAIL single_zero mode=%0d got=%b exp=%b", m, zero, e == 0); end
    exp_res = e;
  endtask

  task automatic mul_op(input int av, input bit poke);
    int e, old;
    old = exp_res;
    e = model(7, av, exp_res);
    mode = 3'd7; a = W'(av); start = 1;
    cycle();
    start = 0;
    for (int i = 0; i < W; i++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL mul_busy iter=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done); end
      checks++; if (result !== (2*W)'(old)) begin failures++; $display("FAIL mul_hold iter=%0d got=%h exp=%h", i, result, old); end
      if (poke) begin start = 1; mode = 3'($urandom_range(0, 7)); a = W'($urandom); end
      cycle();
    end
    start = 0;
    checks++; if (result !== (2*W)'(e)) begin failures++; $display("FAIL mul_res a=%0d got=%h exp=%h", av, result, e); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mul_end got done=%b busy=%b exp done=1 busy=0", done, busy); end
    exp_res = e;
  endtask

  task automatic do_reset();
    reset = 1; start = 0;
    cycle();
    reset = 0;
    exp_res = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cycle(); cycle();
    reset = 0;
    exp_res = 0;
    checks++; if (result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL reset_res got=%h zero=%b exp=00 zero=1", result, zero); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_single();
    single_op(1, 5);
    single_op(1, 3);
    cycle();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end
    checks++; if (result !== 8'h08) begin failures++; $display("FAIL idle_hold got=%h exp=08", result); end
    do_reset(); single_op(0, 8); single_op(5, 3);
    single_op(5, 8);
    single_op(0, 7); single_op(6, 2);
    single_op(0, 5); single_op(3, 10);
    do_reset(); single_op(0, 14); single_op(3, 1); single_op(2, 3);
    do_reset(); single_op(4, 0);
    single_op(4, 9);
  endtask

  task automatic test_mul();
    do_reset(); single_op(0, 12);
    mul_op(15, 1);
    cycle();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mul_after got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) single_op($urandom_range(0, 6), $urandom_range(0, (1 << W) - 1));
    mul_op($urandom_range(0, 15), 1);
    mul_op($urandom_range(0, 15), 0);
    single_op(1, 2);
    mul_op($urandom_range(0, 15), 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int m;
      m = $urandom_range(0, 7);
      if (m == 7) mul_op($urandom_range(0, 15), 1'($urandom));
      else single_op(m, $urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 3) == 0) cycle();
    end
  endtask

  task automatic test_mul_reset();
    do_reset(); single_op(0, 6);
    mode = 3'd7; a = W'(5); start = 1;
    cycle();
    start = 0;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    exp_res = 0;
    checks++; if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mul_abort got res=%h busy=%b done=%b exp 00 0 0", result, busy, done); end
    for (int i = 0; i < W; i++) begin
      cycle();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || result !== '0) begin failures++; $display("FAIL mul_abort_quiet cyc=%0d got res=%h busy=%b done=%b exp 00 0 0", i, result, busy, done); end
    end
    single_op(0, 3);
    reset = 1; start = 1; mode = 3'd1; a = W'(5);
    cycle();
    reset = 0; start = 0;
    checks++; if (result !== '0 || done !== 1'b0) begin failures++; $display("FAIL reset_start got res=%h done=%b exp 00 0", result, done); end
    single_op(0, 3);
    reset = 1; start = 1; mode = 3'd7; a = W'(5);
    cycle();
    reset = 0; start = 0;
    exp_res = 0;
    checks++; if (busy !== 1'b0 || result !== '0) begin failures++; $display("FAIL reset_start_mul got busy=%b res=%h exp 0 00", busy, result); end
    single_op(1, 9);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_mul();
    test_back_to_back();
    test_random();
    test_mul_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
